// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Owns the PC, drives the instruction
//               memory request, and holds the IF/ID pipeline register plus a
//               one-entry skid buffer for words acked while decode stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pause_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_npc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o,
  output logic [31:0] fetch_pc_o
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  logic [1:0]  state_q,      state_d;
  logic [31:0] pc_q,         pc_d;
  logic [31:0] drain_addr_q, drain_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q,  skid_inst_d;
  logic [31:0] skid_pc_q,    skid_pc_d;
  logic        id_valid_q,   id_valid_d;
  logic [31:0] id_inst_q,    id_inst_d;
  logic [31:0] id_pc_q,      id_pc_d;
  logic [31:0] id_npc_q,     id_npc_d;

  // Redirect targets are forced word aligned.
  logic [31:0] w_redirect_tgt;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_skid_npc;
  assign w_redirect_tgt = redirect_pc_i & ~32'd3;
  assign w_pc_plus4     = pc_q + 32'd4;
  assign w_skid_npc     = skid_pc_q + 32'd4;

  // State and datapath registers, asynchronously reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      drain_addr_q <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= NOP_INST;
      skid_pc_q    <= 32'd0;
      id_valid_q   <= 1'b0;
      id_inst_q    <= NOP_INST;
      id_pc_q      <= 32'd0;
      id_npc_q     <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
      id_valid_q   <= id_valid_d;
      id_inst_q    <= id_inst_d;
      id_pc_q      <= id_pc_d;
      id_npc_q     <= id_npc_d;
    end
  end

  // Next-state logic; redirect outranks pause in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (redirect_i)                    state_d = imem_ack_i ? ST_FETCH : ST_DRAIN;
        else if (imem_ack_i && pause_i)    state_d = ST_HOLD;
      end
      // A redirect landing on the ack cycle leaves nothing in flight, so the
      // new target can be fetched straight away.
      ST_DRAIN: if (imem_ack_i)            state_d = ST_FETCH;
      ST_HOLD:  if (redirect_i || !pause_i) state_d = ST_FETCH;
      default:  state_d = ST_BOOT;
    endcase
  end

  // PC, skid buffer and IF/ID register updates.
  always_comb begin
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    id_valid_d   = id_valid_q;
    id_inst_d    = id_inst_q;
    id_pc_d      = id_pc_q;
    id_npc_d     = id_npc_q;
    if (redirect_i) begin
      id_valid_d   = 1'b0;
      id_inst_d    = NOP_INST;
      skid_valid_d = 1'b0;
      pc_d         = w_redirect_tgt;
      // Remember the in-flight address so the drain keeps it stable.
      if (state_q == ST_FETCH && !imem_ack_i) drain_addr_d = pc_q;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ack_i && !pause_i) begin
            id_valid_d = 1'b1;
            id_inst_d  = imem_rdata_i;
            id_pc_d    = pc_q;
            id_npc_d   = w_pc_plus4;
            pc_d       = w_pc_plus4;
          end else if (imem_ack_i) begin
            skid_valid_d = 1'b1;
            skid_inst_d  = imem_rdata_i;
            skid_pc_d    = pc_q;
          end else if (!pause_i) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
          end
        end
        ST_HOLD: begin
          if (!pause_i) begin
            id_valid_d   = skid_valid_q;
            id_inst_d    = skid_inst_q;
            id_pc_d      = skid_pc_q;
            id_npc_d     = w_skid_npc;
            pc_d         = w_pc_plus4;
            skid_valid_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory request decoded from registered state only.
  always_comb begin
    imem_req_o  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    imem_addr_o = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
  end

  assign id_pc_o    = id_pc_q;
  assign id_npc_o   = id_npc_q;
  assign id_inst_o  = id_inst_q;
  assign id_valid_o = id_valid_q;
  assign fetch_pc_o = pc_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed self-checking bench for if_fetch_stage with a simple
//               fixed-latency instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  localparam logic [31:0] C_NOP = 32'h0000_0013;
  localparam logic [31:0] C_KEY = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        pause_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] id_pc_o, id_npc_o, id_inst_o, fetch_pc_o;
  logic        id_valid_o;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int mem_cnt  = 0;
  bit mem_auto = 1'b1;

  if_fetch_stage #(.RESET_PC(32'h0), .NOP_INST(C_NOP)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pause_i(pause_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .id_pc_o(id_pc_o), .id_npc_o(id_npc_o), .id_inst_o(id_inst_o),
    .id_valid_o(id_valid_o), .fetch_pc_o(fetch_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory answers after mem_lat cycles of a held request.
  task automatic mem_drive();
    if (mem_auto) begin
      imem_rdata_i = imem_addr_o ^ C_KEY;
      if (imem_req_o) begin
        if (mem_cnt >= mem_lat - 1) begin
          imem_ack_i = 1'b1;
          mem_cnt    = 0;
        end else begin
          imem_ack_i = 1'b0;
          mem_cnt++;
        end
      end else begin
        imem_ack_i = 1'b0;
        mem_cnt    = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    mem_drive();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   {31'd0, imem_req_o}, 32'd0);
    check_eq({tag, "_valid"}, {31'd0, id_valid_o}, 32'd0);
    check_eq({tag, "_inst"},  id_inst_o, C_NOP);
    check_eq({tag, "_pc"},    id_pc_o, 32'd0);
    check_eq({tag, "_npc"},   id_npc_o, 32'd0);
    check_eq({tag, "_fpc"},   fetch_pc_o, 32'd0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    tick();
    tick();
    rst_i   = 1'b0;
    mem_cnt = 0;
    mem_drive();
  endtask

  initial begin
    // ---------------- Test 1: reset and back-to-back stream ----------------
    #3;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst0");
    do_reset();
    tick();
    check_eq("t1_req",  {31'd0, imem_req_o}, 32'd1);
    check_eq("t1_addr0", imem_addr_o, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_eq("t1_valid", {31'd0, id_valid_o}, 32'd1);
      check_eq("t1_pc",   id_pc_o,   32'(4 * k));
      check_eq("t1_npc",  id_npc_o,  32'(4 * k + 4));
      check_eq("t1_inst", id_inst_o, 32'(4 * k) ^ C_KEY);
      check_eq("t1_addr", imem_addr_o, 32'(4 * k + 4));
    end
    // ack for 0x10 is on the bus now

    // ---------------- Test 2: pause on the 0x10 ack ----------------
    pause_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("t2_req",  {31'd0, imem_req_o}, 32'd0);
      check_eq("t2_pc",   id_pc_o, 32'hC);
      check_eq("t2_inst", id_inst_o, 32'hA5A5_000C);
      check_eq("t2_valid", {31'd0, id_valid_o}, 32'd1);
    end
    pause_i = 1'b0;
    tick();
    check_eq("t2_pc10",   id_pc_o, 32'h10);
    check_eq("t2_inst10", id_inst_o, 32'hA5A5_0010);
    check_eq("t2_npc10",  id_npc_o, 32'h14);
    check_eq("t2_addr14", imem_addr_o, 32'h14);
    tick();
    check_eq("t2_pc14",   id_pc_o, 32'h14);
    check_eq("t2_inst14", id_inst_o, 32'hA5A5_0014);

    // ---------------- Test 3: redirect while a slow fetch is in flight -------
    mem_lat = 3;
    do_reset();
    for (int k = 0; k < 7; k++) tick();
    check_eq("t3_addr8", imem_addr_o, 32'h8);
    check_eq("t3_pc4",   id_pc_o, 32'h4);
    tick();
    check_eq("t3_bubble", {31'd0, id_valid_o}, 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h203;
    tick();
    redirect_i = 1'b0;
    check_eq("t3_drain_req",  {31'd0, imem_req_o}, 32'd1);
    check_eq("t3_drain_addr", imem_addr_o, 32'h8);
    check_eq("t3_fpc",        fetch_pc_o, 32'h200);
    check_eq("t3_flush",      {31'd0, id_valid_o}, 32'd0);
    check_eq("t3_ack_now",    {31'd0, imem_ack_i}, 32'd1);
    tick();
    check_eq("t3_addr200", imem_addr_o, 32'h200);
    check_eq("t3_drop",    {31'd0, id_valid_o}, 32'd0);
    tick();
    check_eq("t3_wait1", {31'd0, id_valid_o}, 32'd0);
    tick();
    check_eq("t3_wait2", {31'd0, id_valid_o}, 32'd0);
    mem_lat = 1;
    tick();
    check_eq("t3_valid", {31'd0, id_valid_o}, 32'd1);
    check_eq("t3_pc",    id_pc_o, 32'h200);
    check_eq("t3_inst",  id_inst_o, 32'hA5A5_0200);

    // ---------------- Test 4: redirect + pause + ack together ----------------
    check_eq("t4_ack", {31'd0, imem_ack_i}, 32'd1);
    pause_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    tick();
    pause_i    = 1'b0;
    redirect_i = 1'b0;
    check_eq("t4_valid", {31'd0, id_valid_o}, 32'd0);
    check_eq("t4_inst",  id_inst_o, C_NOP);
    check_eq("t4_addr",  imem_addr_o, 32'h300);
    check_eq("t4_req",   {31'd0, imem_req_o}, 32'd1);
    tick();
    check_eq("t4_pc300", id_pc_o, 32'h300);

    // ---------------- Test 5: PC wrap at top of memory ----------------
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    redirect_i = 1'b0;
    check_eq("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    check_eq("t5_pc",   id_pc_o, 32'hFFFF_FFFC);
    check_eq("t5_npc",  id_npc_o, 32'h0);
    check_eq("t5_addr", imem_addr_o, 32'h0);
    check_eq("t5_fpc",  fetch_pc_o, 32'h0);
    mem_lat = 3;
    tick();
    check_eq("t5_pc0",  id_pc_o, 32'h0);
    check_eq("t5_npc4", id_npc_o, 32'h4);

    // ---------------- Test 6: async reset with a request pending -------------
    tick();
    check_eq("t6_pending", {31'd0, imem_req_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    check_reset_outputs("t6_async");
    mem_auto     = 1'b0;
    imem_ack_i   = 1'b1;
    imem_rdata_i = 32'hDEAD_BEEF;
    @(posedge clk_i);
    #1;
    check_reset_outputs("t6_held");
    rst_i    = 1'b0;
    mem_auto = 1'b1;
    mem_lat  = 1;
    mem_cnt  = 0;
    tick();
    check_eq("t6_late_ack", {31'd0, id_valid_o}, 32'd0);
    check_eq("t6_restart",  imem_addr_o, 32'h0);
    tick();
    check_eq("t6_pc",   id_pc_o, 32'h0);
    check_eq("t6_inst", id_inst_o, C_KEY);
    check_eq("t6_valid", {31'd0, id_valid_o}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #20000;
    n_fail++;
    $display("FAIL timeout: got running expected finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
